// File: rtl/dift_trap_ctrl_pkg.sv
// rtl/dift_trap_ctrl_pkg.sv - shared DIFT types, constants and trap-type index mapping
package dift_trap_ctrl_pkg;

  // Trap types reported by the tag check unit; NONE means no trap
  typedef enum logic [2:0] {
    DIFT_NONE = 3'd0,
    DIFT_EXEC = 3'd1,
    DIFT_JALR = 3'd2,
    DIFT_BRAN = 3'd3,
    DIFT_STOR = 3'd4,
    DIFT_LOAD = 3'd5
  } dift_trap_t;

  // Trap controller FSM states
  typedef enum logic [1:0] {
    TC_IDLE    = 2'd0,
    TC_PENDING = 2'd1,
    TC_HANDLER = 2'd2
  } dift_trapctrl_state_t;

  localparam int DIFT_CNT_WIDTH = 8;
  localparam int DIFT_NUM_TYPES = 5;

  // Counter slot assigned to each trap type
  localparam logic [2:0] DIFT_IDX_EXEC    = 3'd0;
  localparam logic [2:0] DIFT_IDX_JALR    = 3'd1;
  localparam logic [2:0] DIFT_IDX_BRAN    = 3'd2;
  localparam logic [2:0] DIFT_IDX_STOR    = 3'd3;
  localparam logic [2:0] DIFT_IDX_LOAD    = 3'd4;
  // NONE (and unused encodings) map to a slot that no counter occupies
  localparam logic [2:0] DIFT_IDX_INVALID = 3'd7;

  function automatic logic [2:0] dift_trap_idx(input dift_trap_t t);
    case (t)
      DIFT_EXEC: return DIFT_IDX_EXEC;
      DIFT_JALR: return DIFT_IDX_JALR;
      DIFT_BRAN: return DIFT_IDX_BRAN;
      DIFT_STOR: return DIFT_IDX_STOR;
      DIFT_LOAD: return DIFT_IDX_LOAD;
      default:   return DIFT_IDX_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/dift_sat_counter.sv
// rtl/dift_sat_counter.sv - saturating event counter with synchronous clear
module dift_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Clear beats increment; increment stops at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dift_trap_ctrl.sv
// rtl/dift_trap_ctrl.sv - DIFT trap sequencing, overflow flag and per-type trap counters
module dift_trap_ctrl
  import dift_trap_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = DIFT_CNT_WIDTH,
  parameter int NUM_TYPES = DIFT_NUM_TYPES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trap_i,
  input  dift_trap_t           trap_type_i,
  input  logic [31:0]          trap_pc_i,
  input  logic                 enable_i,
  output logic                 exc_req_o,
  input  logic                 exc_ack_i,
  output dift_trap_t           exc_type_o,
  output logic [31:0]          exc_pc_o,
  input  logic                 trap_done_i,
  output logic                 busy_o,
  output logic                 overflow_o,
  input  logic                 ovf_clear_i,
  input  dift_trap_t           cnt_sel_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  input  logic                 cnt_clear_i
);

  dift_trapctrl_state_t state_q, state_d;
  dift_trap_t           type_q, type_d;
  logic [31:0]          pc_q, pc_d;
  logic                 ovf_q, ovf_d;
  logic                 trap_valid, accept, drop;
  logic [2:0]           trap_idx, sel_idx;
  logic [NUM_TYPES-1:0] inc_vec;
  logic [CNT_WIDTH-1:0] cnt_arr [NUM_TYPES];

  assign trap_valid = trap_i && enable_i && (trap_type_i != DIFT_NONE);
  assign trap_idx   = dift_trap_idx(trap_type_i);
  assign sel_idx    = dift_trap_idx(cnt_sel_i);

  // State, latched trap and sticky overflow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TC_IDLE;
      type_q  <= DIFT_NONE;
      pc_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state: accept a trap when free (or as the handler retires), drop it otherwise
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    drop    = 1'b0;
    case (state_q)
      TC_IDLE: begin
        if (trap_valid) begin
          accept  = 1'b1;
          state_d = TC_PENDING;
        end
      end
      TC_PENDING: begin
        drop = trap_valid;
        if (exc_ack_i) state_d = TC_HANDLER;
      end
      TC_HANDLER: begin
        if (trap_done_i) begin
          if (trap_valid) begin
            accept  = 1'b1;
            state_d = TC_PENDING;
          end else begin
            state_d = TC_IDLE;
          end
        end else begin
          drop = trap_valid;
        end
      end
      default: state_d = TC_IDLE;
    endcase
  end

  // Latch trap details only on acceptance; a drop in the same cycle as a clear keeps the flag set
  always_comb begin
    type_d = accept ? trap_type_i : type_q;
    pc_d   = accept ? trap_pc_i : pc_q;
    ovf_d  = ovf_q;
    if (drop)             ovf_d = 1'b1;
    else if (ovf_clear_i) ovf_d = 1'b0;
  end

  // Outputs decoded from registered state so the request has no combinational path from trap_i
  always_comb begin
    exc_req_o  = (state_q == TC_PENDING);
    busy_o     = (state_q != TC_IDLE);
    exc_type_o = type_q;
    exc_pc_o   = pc_q;
    overflow_o = ovf_q;
  end

  // One saturating counter per trap type; dropped traps count too
  for (genvar g = 0; g < NUM_TYPES; g++) begin : g_cnt
    assign inc_vec[g] = trap_valid && (trap_idx == 3'(g));
    dift_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (inc_vec[g]),
      .clr_i (cnt_clear_i),
      .cnt_o (cnt_arr[g])
    );
  end

  // Counter readback; NONE selects no slot and reads zero
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < NUM_TYPES; i++) begin
      if (sel_idx == 3'(i)) cnt_o = cnt_arr[i];
    end
  end

endmodule

// File: tb/tb_dift_trap_ctrl.sv
// tb/tb_dift_trap_ctrl.sv - scoreboard bench for dift_trap_ctrl
module tb_dift_trap_ctrl;
  import dift_trap_ctrl_pkg::*;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          trap_i;
  dift_trap_t    trap_type_i;
  logic [31:0]   trap_pc_i;
  logic          enable_i;
  logic          exc_req_o;
  logic          exc_ack_i;
  dift_trap_t    exc_type_o;
  logic [31:0]   exc_pc_o;
  logic          trap_done_i;
  logic          busy_o;
  logic          overflow_o;
  logic          ovf_clear_i;
  dift_trap_t    cnt_sel_i;
  logic [CW-1:0] cnt_o;
  logic          cnt_clear_i;

  always #5 clk = ~clk;

  dift_trap_ctrl #(.CNT_WIDTH(CW), .NUM_TYPES(DIFT_NUM_TYPES)) dut (
    .clk         (clk),
    .rst         (rst),
    .trap_i      (trap_i),
    .trap_type_i (trap_type_i),
    .trap_pc_i   (trap_pc_i),
    .enable_i    (enable_i),
    .exc_req_o   (exc_req_o),
    .exc_ack_i   (exc_ack_i),
    .exc_type_o  (exc_type_o),
    .exc_pc_o    (exc_pc_o),
    .trap_done_i (trap_done_i),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o),
    .ovf_clear_i (ovf_clear_i),
    .cnt_sel_i   (cnt_sel_i),
    .cnt_o       (cnt_o),
    .cnt_clear_i (cnt_clear_i)
  );

  typedef struct {
    dift_trap_t  typ;
    logic [31:0] pc;
  } req_t;

  typedef struct {
    string         name;
    logic          req;
    logic          busy;
    logic          ovf;
    dift_trap_t    typ;
    logic [31:0]   pc;
    logic [CW-1:0] cnt;
  } snap_t;

  req_t  req_q[$];
  snap_t snap_q[$];
  int    total = 0;
  int    bad   = 0;
  logic  prev_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every new exception request is matched against the expected request queue,
  // and every queued status snapshot is compared against the outputs at this falling edge.
  always @(negedge clk) begin : mon
    req_t  r;
    snap_t s;
    if (exc_req_o && !prev_req) begin
      chk("req_expected", 32'(req_q.size() != 0), 32'd1);
      if (req_q.size() != 0) begin
        r = req_q.pop_front();
        chk("req_type", 32'(exc_type_o), 32'(r.typ));
        chk("req_pc", exc_pc_o, r.pc);
      end
    end
    prev_req = exc_req_o;
    while (snap_q.size() != 0) begin
      s = snap_q.pop_front();
      chk({s.name, ".req"},  32'(exc_req_o),  32'(s.req));
      chk({s.name, ".busy"}, 32'(busy_o),     32'(s.busy));
      chk({s.name, ".ovf"},  32'(overflow_o), 32'(s.ovf));
      chk({s.name, ".type"}, 32'(exc_type_o), 32'(s.typ));
      chk({s.name, ".pc"},   exc_pc_o,        s.pc);
      chk({s.name, ".cnt"},  32'(cnt_o),      32'(s.cnt));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap(input string nm, input dift_trap_t sel, input logic req, input logic busy,
                      input logic ovf, input dift_trap_t typ, input logic [31:0] pc,
                      input logic [CW-1:0] cnt);
    snap_t s;
    cnt_sel_i = sel;
    s.name = nm; s.req = req; s.busy = busy; s.ovf = ovf;
    s.typ = typ; s.pc = pc; s.cnt = cnt;
    snap_q.push_back(s);
    @(negedge clk);
    #1;
  endtask

  task automatic fire(input dift_trap_t t, input logic [31:0] pc, input logic expect_req);
    trap_i      = 1'b1;
    trap_type_i = t;
    trap_pc_i   = pc;
    if (expect_req) req_q.push_back('{typ: t, pc: pc});
    step();
    trap_i      = 1'b0;
    trap_type_i = DIFT_NONE;
  endtask

  task automatic ack();
    exc_ack_i = 1'b1; step(); exc_ack_i = 1'b0;
  endtask

  task automatic done();
    trap_done_i = 1'b1; step(); trap_done_i = 1'b0;
  endtask

  task automatic ovf_clr();
    ovf_clear_i = 1'b1; step(); ovf_clear_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; trap_i = 1'b0; trap_type_i = DIFT_NONE; trap_pc_i = '0;
    enable_i = 1'b0; exc_ack_i = 1'b0; trap_done_i = 1'b0; ovf_clear_i = 1'b0;
    cnt_sel_i = DIFT_NONE; cnt_clear_i = 1'b0;
    step(2);
    snap("reset", DIFT_LOAD, 0, 0, 0, DIFT_NONE, 32'h0, 0);
    rst = 1'b0;
    enable_i = 1'b1;

    // LOAD trap, request next cycle, ack three cycles later, handler finishes
    fire(DIFT_LOAD, 32'h1000, 1);
    snap("load_req", DIFT_LOAD, 1, 1, 0, DIFT_LOAD, 32'h1000, 1);
    step(2);
    snap("load_hold", DIFT_LOAD, 1, 1, 0, DIFT_LOAD, 32'h1000, 1);
    ack();
    snap("handler", DIFT_LOAD, 0, 1, 0, DIFT_LOAD, 32'h1000, 1);
    done();
    snap("idle_hold", DIFT_LOAD, 0, 0, 0, DIFT_LOAD, 32'h1000, 1);
    ack();
    done();
    snap("idle_ignore", DIFT_LOAD, 0, 0, 0, DIFT_LOAD, 32'h1000, 1);

    // Drops while pending: overflow set, latched values kept, counter still counts
    fire(DIFT_STOR, 32'h3000, 1);
    fire(DIFT_JALR, 32'h4444, 0);
    snap("drop_pend", DIFT_JALR, 1, 1, 1, DIFT_STOR, 32'h3000, 1);
    snap("stor_cnt", DIFT_STOR, 1, 1, 1, DIFT_STOR, 32'h3000, 1);
    ovf_clr();
    snap("ovf_clr", DIFT_JALR, 1, 1, 0, DIFT_STOR, 32'h3000, 1);
    ovf_clear_i = 1'b1;
    fire(DIFT_JALR, 32'h4448, 0);
    ovf_clear_i = 1'b0;
    snap("ovf_set_wins", DIFT_JALR, 1, 1, 1, DIFT_STOR, 32'h3000, 2);
    enable_i = 1'b0;
    ovf_clr();
    snap("en_off_pend", DIFT_JALR, 1, 1, 0, DIFT_STOR, 32'h3000, 2);
    enable_i = 1'b1;
    ack();
    snap("handler2", DIFT_EXEC, 0, 1, 0, DIFT_STOR, 32'h3000, 0);
    fire(DIFT_EXEC, 32'h5555, 0);
    snap("drop_hdl", DIFT_EXEC, 0, 1, 1, DIFT_STOR, 32'h3000, 1);
    ovf_clr();

    // Handler retires in the same cycle as a new trap: straight back to pending
    trap_done_i = 1'b1;
    fire(DIFT_EXEC, 32'h2000, 1);
    trap_done_i = 1'b0;
    snap("done_and_trap", DIFT_EXEC, 1, 1, 0, DIFT_EXEC, 32'h2000, 2);
    done();
    snap("done_in_pend", DIFT_EXEC, 1, 1, 0, DIFT_EXEC, 32'h2000, 2);
    ack();
    done();
    snap("idle2", DIFT_EXEC, 0, 0, 0, DIFT_EXEC, 32'h2000, 2);

    // Invalid pulses are ignored
    enable_i = 1'b0;
    fire(DIFT_BRAN, 32'h9000, 0);
    snap("en_off", DIFT_BRAN, 0, 0, 0, DIFT_EXEC, 32'h2000, 0);
    enable_i = 1'b1;
    fire(DIFT_NONE, 32'h9004, 0);
    snap("type_none", DIFT_NONE, 0, 0, 0, DIFT_EXEC, 32'h2000, 0);
    snap("none_load_cnt", DIFT_LOAD, 0, 0, 0, DIFT_EXEC, 32'h2000, 1);

    // Two-bit counter saturation, then clear coincident with a fifth trap
    fire(DIFT_BRAN, 32'h6000, 1);
    snap("bran1", DIFT_BRAN, 1, 1, 0, DIFT_BRAN, 32'h6000, 1);
    fire(DIFT_BRAN, 32'h6004, 0);
    snap("bran2", DIFT_BRAN, 1, 1, 1, DIFT_BRAN, 32'h6000, 2);
    fire(DIFT_BRAN, 32'h6008, 0);
    snap("bran3", DIFT_BRAN, 1, 1, 1, DIFT_BRAN, 32'h6000, 3);
    fire(DIFT_BRAN, 32'h600c, 0);
    snap("bran4", DIFT_BRAN, 1, 1, 1, DIFT_BRAN, 32'h6000, 3);
    ovf_clr();
    ack();
    done();
    cnt_clear_i = 1'b1;
    fire(DIFT_BRAN, 32'h6100, 1);
    cnt_clear_i = 1'b0;
    snap("clr_wins", DIFT_BRAN, 1, 1, 0, DIFT_BRAN, 32'h6100, 0);
    snap("clr_load", DIFT_LOAD, 1, 1, 0, DIFT_BRAN, 32'h6100, 0);

    // Reset between clock edges while pending
    step();
    #2;
    rst = 1'b1;
    snap("rst_async", DIFT_LOAD, 0, 0, 0, DIFT_NONE, 32'h0, 0);
    step();
    rst = 1'b0;
    step(3);
    snap("post_rst", DIFT_LOAD, 0, 0, 0, DIFT_NONE, 32'h0, 0);

    step(2);
    chk("req_queue_drained", 32'(req_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
